// File: rtl/mul_pkg.sv
// mul_pkg: shared constants and types for the multiplier operand path.
//   REGISTER_SIZE / NUM_BITS / DESIRED_SIZE : default chunk, operand and
//                                             accumulator widths
//   N_WORDS, PAD_W                           : derived word count and width
//                                             of the row-offset field
//   feeder_state_t                           : operand feeder state encoding
//   clog2_min1()                             : counter width helper, never 0
package mul_pkg;

    localparam int REGISTER_SIZE   = 32;
    localparam int NUM_BITS        = 2048;
    localparam int DESIRED_SIZE    = 2080;
    localparam int ROW_GAP_DEFAULT = 140;

    localparam int N_WORDS = NUM_BITS / REGISTER_SIZE;
    localparam int PAD_W   = $clog2(DESIRED_SIZE) + 1;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        ROW_WAIT,
        ROW_ISSUE,
        DRAIN
    } feeder_state_t;

    // A 1-word operand still needs a 1-bit counter.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/mul_feeder_out_pipe.sv
// mul_feeder_out_pipe: two-stage shift that carries valid, last and the row
// offset alongside the 2-cycle BRAM read so they leave with the data.
//   clk_in, rst_in : clock, synchronous active-high reset (flushes valids)
//   valid_in       : a read address is being issued this cycle
//   last_in        : that address is the last word of the row
//   pad_in         : row index for that address
//   valid_mid      : stage-1 valid; enables the BRAM output register
//   valid_out/last_out/pad_out : aligned with the BRAM output register
module mul_feeder_out_pipe #(
    parameter int PAD_W = 12
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    input  logic             last_in,
    input  logic [PAD_W-1:0] pad_in,
    output logic             valid_mid,
    output logic             valid_out,
    output logic             last_out,
    output logic [PAD_W-1:0] pad_out
);

    logic             last_mid;
    logic [PAD_W-1:0] pad_mid;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_mid <= 1'b0;
            last_mid  <= 1'b0;
            pad_mid   <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            pad_out   <= '0;
        end else begin
            valid_mid <= valid_in;
            last_mid  <= last_in;
            pad_mid   <= pad_in;
            valid_out <= valid_mid;
            last_out  <= last_mid;
            pad_out   <= pad_mid;
        end
    end

endmodule

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
// xilinx_true_dual_port_read_first_2_clock_ram: dual-port block RAM,
// read-first, with an output register on each port (2-cycle read latency).
//   addra/dina/wea/ena/regcea/rsta/douta : port A, clocked by clka
//   addrb/dinb/web/enb/regceb/rstb/doutb : port B, reads clocked by clkb
// Both write ports commit on clka so the array has a single writer; port B
// writes are only valid when clkb is the same clock as clka.
// rsta/rstb synchronously clear the output registers, not the array.
module xilinx_true_dual_port_read_first_2_clock_ram #(
    parameter int RAM_WIDTH = 32,
    parameter int RAM_DEPTH = 1024
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic [RAM_WIDTH-1:0]         dinb,
    input  logic                         clka,
    input  logic                         clkb,
    input  logic                         wea,
    input  logic                         web,
    input  logic                         ena,
    input  logic                         enb,
    input  logic                         rsta,
    input  logic                         rstb,
    input  logic                         regcea,
    input  logic                         regceb,
    output logic [RAM_WIDTH-1:0]         douta,
    output logic [RAM_WIDTH-1:0]         doutb
);

    logic [RAM_WIDTH-1:0] bram [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data_a;
    logic [RAM_WIDTH-1:0] ram_data_b;

    always_ff @(posedge clka) begin
        if (ena && wea) begin
            bram[addra] <= dina;
        end
        if (enb && web) begin
            bram[addrb] <= dinb;
        end
    end

    always_ff @(posedge clka) begin
        if (ena) begin
            ram_data_a <= bram[addra];
        end
    end

    always_ff @(posedge clkb) begin
        if (enb) begin
            ram_data_b <= bram[addrb];
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            douta <= '0;
        end else if (regcea) begin
            douta <= ram_data_a;
        end
    end

    always_ff @(posedge clkb) begin
        if (rstb) begin
            doutb <= '0;
        end else if (regceb) begin
            doutb <= ram_data_b;
        end
    end

endmodule

// File: rtl/mul_operand_feeder.sv
// mul_operand_feeder: loads operands A then B (LS word first) into a BRAM
// and replays the schoolbook word-pair schedule: for each row j it streams
// A[0..N-1] paired with B[j], tagged with start_padding_out = j.
//   clk_in, rst_in          : clock, synchronous active-high reset
//   data_in, valid_in       : operand words, accepted while ready_out = 1
//   ready_out               : high in LOAD_A / LOAD_B
//   ready_in                : accumulator ready, sampled only at row start
//   a_out, b_out            : operand word pair
//   start_padding_out       : row index j (zero-extended)
//   valid_out, last_out     : word valid / last word of the row
//   done_out                : one-cycle pulse after the final row
// Optional build macro MUL_FEEDER_SKIP_ZERO_ROW_EN: rows whose B word is
// zero are skipped without issuing anything.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// LOAD_A    | accepting A words into BRAM 0..N-1
// LOAD_B    | accepting B words into BRAM N..2N-1
// ROW_WAIT  | gap timer running down; start row when expired and ready_in
// ROW_ISSUE | one A read address per cycle, i = 0..N-1
// DRAIN     | 2 cycles for the read pipeline to empty, then next row/done
module mul_operand_feeder
    import mul_pkg::*;
#(
    parameter int register_size = REGISTER_SIZE,
    parameter int num_bits      = NUM_BITS,
    parameter int desired_size  = DESIRED_SIZE,
    parameter int ROW_GAP       = ROW_GAP_DEFAULT
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [register_size-1:0]        data_in,
    input  logic                            valid_in,
    output logic                            ready_out,
    input  logic                            ready_in,
    output logic [register_size-1:0]        a_out,
    output logic [register_size-1:0]        b_out,
    output logic [$clog2(desired_size):0]   start_padding_out,
    output logic                            valid_out,
    output logic                            last_out,
    output logic                            done_out
);

    localparam int N  = num_bits / register_size;
    localparam int CW = clog2_min1(N);
    localparam int AW = clog2_min1(2 * N);
    localparam int PW = $clog2(desired_size) + 1;
    localparam int GW = (ROW_GAP > 0) ? $clog2(ROW_GAP + 1) : 1;

    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
    localparam logic [GW-1:0] GAP_INIT = GW'(ROW_GAP);

    feeder_state_t state;
    logic [CW-1:0] word_cnt;
    logic [CW-1:0] row_j;
    logic [CW-1:0] rd_i;
    logic [GW-1:0] gap_cnt;
    logic          drain_cnt;

`ifdef MUL_FEEDER_SKIP_ZERO_ROW_EN
    logic [N-1:0]  zero_flag;
`endif

    logic          issue;
    logic          wr_en;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic          pipe_valid_mid;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= LOAD_A;
            word_cnt  <= '0;
            row_j     <= '0;
            rd_i      <= '0;
            gap_cnt   <= '0;
            drain_cnt <= 1'b0;
            ready_out <= 1'b1;
            done_out  <= 1'b0;
        end else begin
            done_out <= 1'b0;
            unique case (state)
                LOAD_A: begin
                    if (valid_in) begin
                        if (word_cnt == LAST_IDX) begin
                            word_cnt <= '0;
                            state    <= LOAD_B;
                        end else begin
                            word_cnt <= word_cnt + CW'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (valid_in) begin
`ifdef MUL_FEEDER_SKIP_ZERO_ROW_EN
                        zero_flag[word_cnt] <= (data_in == '0);
`endif
                        if (word_cnt == LAST_IDX) begin
                            word_cnt  <= '0;
                            row_j     <= '0;
                            gap_cnt   <= '0;
                            ready_out <= 1'b0;
                            state     <= ROW_WAIT;
                        end else begin
                            word_cnt <= word_cnt + CW'(1);
                        end
                    end
                end
                ROW_WAIT: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
`ifdef MUL_FEEDER_SKIP_ZERO_ROW_EN
                    // A skipped row consumes no gap: the timer is left alone.
                    if (zero_flag[row_j]) begin
                        if (row_j == LAST_IDX) begin
                            row_j     <= '0;
                            done_out  <= 1'b1;
                            ready_out <= 1'b1;
                            state     <= LOAD_A;
                        end else begin
                            row_j <= row_j + CW'(1);
                        end
                    end else
`endif
                    if (gap_cnt == '0 && ready_in) begin
                        rd_i  <= '0;
                        state <= ROW_ISSUE;
                    end
                end
                ROW_ISSUE: begin
                    if (rd_i == LAST_IDX) begin
                        rd_i      <= '0;
                        drain_cnt <= 1'b1;
                        state     <= DRAIN;
                    end else begin
                        rd_i <= rd_i + CW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        drain_cnt <= 1'b0;
                    end else if (row_j == LAST_IDX) begin
                        row_j     <= '0;
                        done_out  <= 1'b1;
                        ready_out <= 1'b1;
                        state     <= LOAD_A;
                    end else begin
                        row_j   <= row_j + CW'(1);
                        gap_cnt <= GAP_INIT;
                        state   <= ROW_WAIT;
                    end
                end
                default: begin
                    ready_out <= 1'b1;
                    state     <= LOAD_A;
                end
            endcase
        end
    end

    assign issue  = (state == ROW_ISSUE);
    assign wr_en  = valid_in && ((state == LOAD_A) || (state == LOAD_B));
    assign addr_b = AW'(N) + AW'(row_j);

    // Port A is shared: write address while loading, A read address otherwise.
    always_comb begin
        addr_a = AW'(rd_i);
        if (state == LOAD_A) begin
            addr_a = AW'(word_cnt);
        end else if (state == LOAD_B) begin
            addr_a = AW'(N) + AW'(word_cnt);
        end
    end

    xilinx_true_dual_port_read_first_2_clock_ram #(
        .RAM_WIDTH (register_size),
        .RAM_DEPTH (2 * N)
    ) u_ram (
        .addra  (addr_a),
        .addrb  (addr_b),
        .dina   (data_in),
        .dinb   ('0),
        .clka   (clk_in),
        .clkb   (clk_in),
        .wea    (wr_en),
        .web    (1'b0),
        .ena    (1'b1),
        .enb    (1'b1),
        .rsta   (rst_in),
        .rstb   (rst_in),
        // Output registers only advance with issued words, so a_out/b_out
        // hold their last row values (or reset zeros) between rows.
        .regcea (pipe_valid_mid),
        .regceb (pipe_valid_mid),
        .douta  (a_out),
        .doutb  (b_out)
    );

    mul_feeder_out_pipe #(
        .PAD_W (PW)
    ) u_out_pipe (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .valid_in  (issue),
        .last_in   (issue && (rd_i == LAST_IDX)),
        .pad_in    (PW'(row_j)),
        .valid_mid (pipe_valid_mid),
        .valid_out (valid_out),
        .last_out  (last_out),
        .pad_out   (start_padding_out)
    );

endmodule

// File: tb/tb_mul_operand_feeder.sv
// tb_mul_operand_feeder: scoreboard bench for mul_operand_feeder with
// N = 4 words, ROW_GAP = 3. Loads push the expected word-pair schedule into
// a queue; a monitor pops and compares every valid_out word.
// Honours MUL_FEEDER_SKIP_ZERO_ROW_EN in its reference model.
module tb_mul_operand_feeder;

    localparam int RS  = 32;
    localparam int NB  = 128;
    localparam int DS  = 2080;
    localparam int GAP = 3;
    localparam int N   = NB / RS;
    localparam int PW  = $clog2(DS) + 1;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic [RS-1:0] data_in = '0;
    logic          valid_in = 1'b0;
    logic          ready_out;
    logic          ready_in = 1'b1;
    logic [RS-1:0] a_out;
    logic [RS-1:0] b_out;
    logic [PW-1:0] start_padding_out;
    logic          valid_out;
    logic          last_out;
    logic          done_out;

    mul_operand_feeder #(
        .register_size (RS),
        .num_bits      (NB),
        .desired_size  (DS),
        .ROW_GAP       (GAP)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .data_in           (data_in),
        .valid_in          (valid_in),
        .ready_out         (ready_out),
        .ready_in          (ready_in),
        .a_out             (a_out),
        .b_out             (b_out),
        .start_padding_out (start_padding_out),
        .valid_out         (valid_out),
        .last_out          (last_out),
        .done_out          (done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [RS-1:0] a;
        logic [RS-1:0] b;
        int            pad;
        bit            last;
        int            idx;
    } exp_t;

    exp_t          exp_q[$];
    logic [RS-1:0] a_ops[N];
    logic [RS-1:0] b_ops[N];
    int            errors = 0;
    int            checks = 0;
    int            done_seen = 0;
    int            done_base = 0;
    bit            prev_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Schoolbook schedule: row j pairs every A word with B[j], offset j.
    function automatic void push_sched();
        for (int j = 0; j < N; j++) begin
`ifdef MUL_FEEDER_SKIP_ZERO_ROW_EN
            if (b_ops[j] == '0) continue;
`endif
            for (int i = 0; i < N; i++) begin
                exp_q.push_back('{a: a_ops[i], b: b_ops[j], pad: j,
                                  last: (i == N - 1), idx: i});
            end
        end
    endfunction

    // Monitor
    always @(posedge clk_in) begin
        exp_t e;
        #1;
        if (done_out) done_seen++;
        if (valid_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word actual a=%0h b=%0h pad=%0d required=none at %0t",
                         a_out, b_out, start_padding_out, $time);
            end else begin
                e = exp_q.pop_front();
                chk("a_out", 64'(a_out), 64'(e.a));
                chk("b_out", 64'(b_out), 64'(e.b));
                chk("start_padding", 64'(start_padding_out), 64'(e.pad));
                chk("last_out", 64'(last_out), 64'(e.last));
                // Words inside a row are back-to-back; a row starts after idle.
                chk("contiguous", 64'(prev_valid), 64'(e.idx != 0));
            end
        end
        prev_valid = valid_out;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic load_operands(input bit toggle);
        done_base = done_seen;
        push_sched();
        for (int k = 0; k < 2 * N; k++) begin
            if (toggle) begin
                @(negedge clk_in);
                valid_in = 1'b0;
                data_in  = $urandom();
            end
            @(negedge clk_in);
            chk("ready_load", 64'(ready_out), 64'd1);
            valid_in = 1'b1;
            data_in  = (k < N) ? a_ops[k] : b_ops[k - N];
        end
        @(negedge clk_in);
        valid_in = 1'b0;
        chk("ready_drop", 64'(ready_out), 64'd0);
        // Beats outside the load states must be ignored.
        repeat (2) begin
            @(negedge clk_in);
            valid_in = 1'b1;
            data_in  = $urandom();
        end
        @(negedge clk_in);
        valid_in = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_seen == done_base && n < 3000) begin
            @(posedge clk_in);
            #2;
            n++;
        end
        chk({name, "_done_seen"}, 64'(done_seen > done_base), 64'd1);
        repeat (5) @(negedge clk_in);
        chk({name, "_done_once"}, 64'(done_seen - done_base), 64'd1);
        chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_ready_idle"}, 64'(ready_out), 64'd1);
    endtask

    task automatic set_fixed();
        for (int k = 0; k < N; k++) begin
            a_ops[k] = RS'(k + 1);
            b_ops[k] = RS'(k + 5);
        end
    endtask

    task automatic set_random();
        for (int k = 0; k < N; k++) begin
            a_ops[k] = $urandom();
            b_ops[k] = $urandom();
        end
    endtask

    initial begin
        int  n;
        int  vcount;
        bit  found;

        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        chk("rst_ready", 64'(ready_out), 64'd1);
        chk("rst_valid", 64'(valid_out), 64'd0);
        chk("rst_last", 64'(last_out), 64'd0);
        chk("rst_done", 64'(done_out), 64'd0);
        chk("rst_a", 64'(a_out), 64'd0);
        chk("rst_b", 64'(b_out), 64'd0);
        chk("rst_pad", 64'(start_padding_out), 64'd0);
        rst_in = 1'b0;

        // Basic schedule A={1,2,3,4}, B={5,6,7,8}
        set_fixed();
        load_operands(1'b0);
        wait_done("basic");

        // ready_in held low before row 1
        set_random();
        load_operands(1'b0);
        found = 1'b0;
        n = 0;
        while (!found && n < 500) begin
            @(posedge clk_in);
            #2;
            n++;
            found = valid_out && last_out && (start_padding_out == '0);
        end
        chk("reach_row0_end", 64'(found), 64'd1);
        @(negedge clk_in);
        ready_in = 1'b0;
        vcount = 0;
        repeat (20) begin
            @(negedge clk_in);
            if (valid_out) vcount++;
        end
        chk("hold_no_valid", 64'(vcount), 64'd0);
        ready_in = 1'b1;
        n = 0;
        do begin
            @(posedge clk_in);
            #2;
            n++;
        end while (!valid_out && n < 20);
        chk("ready_latency", 64'(n), 64'd3);
        wait_done("ready_hold");

        // Reset in the middle of row 2
        set_random();
        load_operands(1'b0);
        found = 1'b0;
        n = 0;
        while (!found && n < 500) begin
            @(posedge clk_in);
            #2;
            n++;
            found = valid_out && (start_padding_out == PW'(2));
        end
        chk("reach_row2", 64'(found), 64'd1);
        done_base = done_seen;
        @(negedge clk_in);
        rst_in = 1'b1;
        exp_q.delete();
        @(negedge clk_in);
        rst_in = 1'b0;
        vcount = 0;
        for (int c = 0; c < 6; c++) begin
            if (valid_out) vcount++;
            chk("rst_mid_ready", 64'(ready_out), 64'd1);
            @(negedge clk_in);
        end
        chk("rst_mid_valid", 64'(vcount), 64'd0);
        chk("rst_mid_no_done", 64'(done_seen - done_base), 64'd0);
        set_random();
        load_operands(1'b0);
        wait_done("reload");

        // valid_in toggled during load
        set_fixed();
        load_operands(1'b1);
        wait_done("toggle");

        // Sparse B: rows with zero B words
        set_random();
        b_ops[0] = '0;
        b_ops[1] = 32'd9;
        b_ops[2] = '0;
        b_ops[3] = '0;
        load_operands(1'b0);
        wait_done("sparse");

        // All-zero B
        set_random();
        for (int k = 0; k < N; k++) b_ops[k] = '0;
        load_operands(1'b0);
        wait_done("all_zero");

        // Random operands, random ready_in pattern between rows
        for (int t = 0; t < 3; t++) begin
            set_random();
            if ($urandom_range(1, 0) == 1) b_ops[$urandom_range(N - 1, 0)] = '0;
            load_operands(1'b0);
            n = 0;
            while (done_seen == done_base && n < 3000) begin
                @(negedge clk_in);
                ready_in = ($urandom_range(3, 0) != 0);
                n++;
            end
            ready_in = 1'b1;
            wait_done("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
